// File: rtl/pll_lock_reset.sv
// rtl/pll_lock_reset.sv - lock-qualified system reset generator for the PLL clock domain
// Synchronizes the PLL lock flag, qualifies it, then releases a registered reset.
module pll_lock_reset #(
  parameter int STABLE_CYCLES = 1024,
  parameter int HOLD_CYCLES   = 16,
  parameter int CNT_WIDTH     = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       locked_in,
  input  logic       soft_reset_req,
  output logic       reset_out,
  output logic       ready,
  output logic       ready_pulse,
  output logic [7:0] lock_loss_count,
  output logic [1:0] state_out
);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    HOLD      = 2'd2,
    RUN       = 2'd3
  } state_t;

  localparam logic [CNT_WIDTH-1:0] STABLE_LOAD = CNT_WIDTH'(STABLE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] HOLD_LOAD   = CNT_WIDTH'(HOLD_CYCLES - 1);

  logic                 sync1_q, sync1_d;
  logic                 locked_sync_q, locked_sync_d;
  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 reset_out_q, reset_out_d;
  logic                 ready_q, ready_d;
  logic                 ready_pulse_q, ready_pulse_d;
  logic [7:0]           loss_q, loss_d;

  always_comb begin
    sync1_d       = locked_in;
    locked_sync_d = sync1_q;
    state_d       = state_q;
    cnt_d         = cnt_q;
    reset_out_d   = reset_out_q;
    ready_d       = ready_q;
    ready_pulse_d = 1'b0;
    loss_d        = loss_q;

    unique case (state_q)
      WAIT_LOCK: begin
        reset_out_d = 1'b1;
        ready_d     = 1'b0;
        if (locked_sync_q) begin
          cnt_d   = STABLE_LOAD;
          state_d = STABLE;
        end
      end
      STABLE: begin
        if (!locked_sync_q) begin
          state_d = WAIT_LOCK;
        end else if (cnt_q == '0) begin
          cnt_d   = HOLD_LOAD;
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      HOLD: begin
        if (!locked_sync_q) begin
          state_d = WAIT_LOCK;
        end else if (cnt_q == '0) begin
          state_d       = RUN;
          reset_out_d   = 1'b0;
          ready_d       = 1'b1;
          ready_pulse_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RUN: begin
        // Lock loss outranks a concurrent soft request and is the only counted loss.
        if (!locked_sync_q) begin
          state_d     = WAIT_LOCK;
          reset_out_d = 1'b1;
          ready_d     = 1'b0;
          if (loss_q != 8'hFF) loss_d = loss_q + 8'd1;
        end else if (soft_reset_req) begin
          cnt_d       = HOLD_LOAD;
          state_d     = HOLD;
          reset_out_d = 1'b1;
          ready_d     = 1'b0;
        end
      end
      default: state_d = WAIT_LOCK;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q       <= 1'b0;
      locked_sync_q <= 1'b0;
      state_q       <= WAIT_LOCK;
      cnt_q         <= '0;
      reset_out_q   <= 1'b1;
      ready_q       <= 1'b0;
      ready_pulse_q <= 1'b0;
      loss_q        <= 8'd0;
    end else begin
      sync1_q       <= sync1_d;
      locked_sync_q <= locked_sync_d;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      reset_out_q   <= reset_out_d;
      ready_q       <= ready_d;
      ready_pulse_q <= ready_pulse_d;
      loss_q        <= loss_d;
    end
  end

  assign reset_out       = reset_out_q;
  assign ready           = ready_q;
  assign ready_pulse     = ready_pulse_q;
  assign lock_loss_count = loss_q;
  assign state_out       = state_q;

endmodule
